fpu_sample_checker: RTL
=======================

// Module: fpu_sample_checker
// PURPOSE
//  Consumer end of the FPU sample-vector flow: accepts {operand, expected} vectors, drives the operand into a unary FPU
//  unit under test (fneg, fabs, fsqrt...), waits the unit's latency, compares its result to the expected word, tallies
//  pass/fail and captures the first mismatch. Lets the same vectors our sample generators print run on hardware/FPGA.
// PARAMETERS
//  LATENCY  1   DUT cycles from dut_op applied to dut_result valid; 0 = combinational DUT; legal 0..15
//  TOL      0   max allowed |got-exp| in ULPs (raw 31-bit magnitude diff, same sign only); 0 = exact bit match
//  CNT_W    32  width of pass/fail counters
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rstn          in   1      asynchronous active-low reset
//  start         in   1      pulse: clear counters/capture, begin run (honoured in IDLE/DONE only)
//  in_valid      in   1      vector valid
//  in_ready      out  1      checker accepts vector this cycle
//  in_op         in   32     operand to apply
//  in_exp        in   32     expected DUT result
//  in_last       in   1      qualifies final vector of stream (with in_valid&in_ready)
//  dut_op        out  32     operand to DUT (registered)
//  dut_result    in   32     DUT result
//  pass_count    out  CNT_W  vectors matched
//  fail_count    out  CNT_W  vectors mismatched
//  ff_valid      out  1      first-failure capture holds data
//  ff_op/ff_got/ff_exp out 32 each  operand, DUT result, expected of first failure
//  busy          out  1      state is RUN or DRAIN
//  done          out  1      state is DONE (level)
// BEHAVIOUR
//  Reset (rstn=0, async): state IDLE; in_ready, busy, done, ff_valid 0; counters 0; dut_op, ff_* 32'h0; tag pipe empty.
//  States: IDLE -start-> RUN; RUN -accepted in_last-> DRAIN; DRAIN -pipe empty-> DONE; DONE -start-> RUN.
//   start in RUN/DRAIN ignored. start entering RUN clears counters, ff_valid, ff_*.
//  Handshake: in_ready = (state==RUN), combinational from state. Accept = in_valid & in_ready; one vector/cycle max;
//   in_* may change freely when not accepted. No vector accepted in the in_last cycle's successor states.
//  Accept edge: dut_op <= in_op; tag {valid,op,exp} enters stage 0. dut_op holds until next accept.
//  Tags shift one stage/cycle; tag at stage LATENCY is evaluated at that edge using dut_result as sampled then
//   (LATENCY=0: compared at the edge after accept, dut_result is combinational from dut_op). Throughput 1/cycle.
//  Match: TOL=0 -> dut_result==exp. TOL>0 -> exact match OR (sign equal AND |got[30:0]-exp[30:0]| <= TOL),
//   computed with 32-bit unsigned diff, no wrap.
//  Match -> pass_count+1; else fail_count+1; counters saturate at all-ones (no wrap).
//  First mismatch while ff_valid=0: latch ff_op/ff_got/ff_exp, set ff_valid; later mismatches never overwrite.
//  DRAIN exits the edge after the last tag is evaluated; done rises that edge. Total latency last accept -> done:
//   LATENCY+2 cycles.
//  in_last with zero prior vectors is fine (single-vector run). start and accept in same cycle impossible (in_ready=0).
//  Reset mid-run: everything returns to reset values immediately; in-flight tags discarded, not counted.
// STRUCTURE
//  fpu_test_pkg (shared): typedef logic [31:0] fword_t; enum chk_state_t {CHK_IDLE,CHK_RUN,CHK_DRAIN,CHK_DONE};
//   struct sample_tag_t {valid, fword_t op, fword_t exp}; function ulp_close(got,exp,tol).
//  One sub-module: sample_delay_line #(DEPTH) - shift register of sample_tag_t, async clear, reports empty.
//  Top: FSM, handshake, dut_op register, compare, saturating counters, first-fail capture.
// TESTING
//  1 fneg DUT, LATENCY=0, TOL=0: vectors (3F800000->BF800000),(00000000->80000000),(FF800000->7F800000), last on 3rd
//    -> pass=3, fail=0, ff_valid=0, done 2 cycles after last accept.
//  2 Same DUT, exp of vector 2 = 00000000, vector 4 wrong too -> fail=2, ff={00000000,80000000,00000000}.
//  3 Registered identity DUT, LATENCY=3, TOL=1: exp=got+1 pass, exp=got+2 fail, exp sign-flipped fail -> pass=1, fail=2.
//  4 Back-to-back 10000 random fneg vectors, in_valid held high -> in_ready high every RUN cycle, pass=10000,
//    busy cleared 3+LATENCY-1 cycles after last accept.
//  5 CNT_W=4, 20 matching vectors -> pass_count sticks at 4'hF.
//  6 rstn low mid-run with 2 tags in flight -> all outputs reset at once; then start -> counters 0, new run clean.

Source files
------------

// File: rtl/fpu_test_pkg.sv
// Shared types for the FPU sample-vector checker.
// Word type, checker states, in-flight sample tag, ULP compare helper.
package fpu_test_pkg;

    typedef logic [31:0] fword_t;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_RUN,
        CHK_DRAIN,
        CHK_DONE
    } chk_state_t;

    typedef struct packed {
        logic   valid;
        fword_t op;
        fword_t exp;
    } sample_tag_t;

    // Exact match, or same sign with magnitudes within tol raw steps.
    // Magnitudes are 31 bits, so the 32-bit difference never wraps.
    function automatic logic ulp_close(
        input fword_t      got,
        input fword_t      exp_w,
        input logic [31:0] tol
    );
        logic [31:0] mg;
        logic [31:0] me;
        logic [31:0] diff;
        mg   = {1'b0, got[30:0]};
        me   = {1'b0, exp_w[30:0]};
        diff = (mg >= me) ? (mg - me) : (me - mg);
        return (got == exp_w) ||
               ((got[31] == exp_w[31]) && (diff <= tol));
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Fixed-depth shift register of sample tags, async cleared.
// Ports: clk, rstn, tag_i (enters stage 0), tag_o (last stage), empty_o.
module sample_delay_line
    import fpu_test_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  sample_tag_t tag_i,
    output sample_tag_t tag_o,
    output logic        empty_o
);

    sample_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (stage_q[i].valid) begin
                empty_o = 1'b0;
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fpu_sample_checker.sv
// Drives {operand, expected} vectors into a unary FPU unit and checks results.
// Ports: start/in_* stream in, dut_op/dut_result to the unit, counters, first-fail, busy/done.
module fpu_sample_checker
    import fpu_test_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TOL     = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op,
    input  logic [31:0]      in_exp,
    input  logic             in_last,
    output logic [31:0]      dut_op,
    input  logic [31:0]      dut_result,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             ff_valid,
    output logic [31:0]      ff_op,
    output logic [31:0]      ff_got,
    output logic [31:0]      ff_exp,
    output logic             busy,
    output logic             done
);

    chk_state_t       state_q;
    fword_t           dut_op_q;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ffv_q, ffv_d;
    fword_t           ffo_q, ffo_d;
    fword_t           ffg_q, ffg_d;
    fword_t           ffe_q, ffe_d;

    logic        accept;
    logic        start_run;
    logic        match;
    logic        pipe_empty;
    sample_tag_t tag_in;
    sample_tag_t tag_out;

    assign in_ready  = (state_q == CHK_RUN);
    assign accept    = in_valid & in_ready;
    assign start_run = start &
                       ((state_q == CHK_IDLE) || (state_q == CHK_DONE));

    assign tag_in = '{valid: accept, op: in_op, exp: in_exp};

    // Stage LATENCY is evaluated on the edge that shifts it out,
    // so the line holds LATENCY+1 stages.
    sample_delay_line #(
        .DEPTH (LATENCY + 1)
    ) u_line (
        .clk     (clk),
        .rstn    (rstn),
        .tag_i   (tag_in),
        .tag_o   (tag_out),
        .empty_o (pipe_empty)
    );

    assign match = ulp_close(dut_result, tag_out.exp, 32'(TOL));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CHK_IDLE;
        end else begin
            unique case (state_q)
                CHK_IDLE:  if (start_run) state_q <= CHK_RUN;
                CHK_RUN:   if (accept && in_last) state_q <= CHK_DRAIN;
                CHK_DRAIN: if (pipe_empty) state_q <= CHK_DONE;
                CHK_DONE:  if (start_run) state_q <= CHK_RUN;
                default:   state_q <= CHK_IDLE;
            endcase
        end
    end

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        ffo_d  = ffo_q;
        ffg_d  = ffg_q;
        ffe_d  = ffe_q;
        if (start_run) begin
            pass_d = '0;
            fail_d = '0;
            ffv_d  = 1'b0;
            ffo_d  = '0;
            ffg_d  = '0;
            ffe_d  = '0;
        end else if (tag_out.valid) begin
            if (match) begin
                if (!(&pass_q)) pass_d = pass_q + CNT_W'(1);
            end else begin
                if (!(&fail_q)) fail_d = fail_q + CNT_W'(1);
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffo_d = tag_out.op;
                    ffg_d = dut_result;
                    ffe_d = tag_out.exp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dut_op_q <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            ffv_q    <= 1'b0;
            ffo_q    <= '0;
            ffg_q    <= '0;
            ffe_q    <= '0;
        end else begin
            if (accept) dut_op_q <= in_op;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            ffo_q  <= ffo_d;
            ffg_q  <= ffg_d;
            ffe_q  <= ffe_d;
        end
    end

    assign dut_op     = dut_op_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign ff_valid   = ffv_q;
    assign ff_op      = ffo_q;
    assign ff_got     = ffg_q;
    assign ff_exp     = ffe_q;
    assign busy       = (state_q == CHK_RUN) || (state_q == CHK_DRAIN);
    assign done       = (state_q == CHK_DONE);

endmodule
